alpha_blender: RTL and testbench

- Per-pixel alpha compositor in the render back end, between the fragment/pixel source and the frame-buffer memory port.
- For each incoming source pixel (r,g,b,a), it requests the current destination pixel from the frame buffer. It then writes back the 8-bit-per-channel blend src*a + dst*(255-a), scaled by 1/256.
- It also forwards an end-of-frame indication once every accepted pixel has been written.

---
 rtl/alpha_blender_pkg.sv | 17 +
 rtl/alpha_channel_mix.sv | 33 +++
 rtl/alpha_blender.sv | 137 +++++++++++++
 tb/tb_alpha_blender.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alpha_blender_pkg.sv
// Shared types and constants for the alpha_blender compositor.
// The ALPHA_BLENDER_ROUND_EN build option is applied in alpha_channel_mix.
package alpha_blender_pkg;

  typedef logic [7:0]  channel_t;
  typedef logic [18:0] pixel_idx_t;

  typedef struct packed {
    channel_t r;
    channel_t g;
    channel_t b;
    channel_t a;
  } rgba_t;

  localparam channel_t ALPHA_MAX = 8'd255;

endpackage

// File: rtl/alpha_channel_mix.sv
// Single-channel blend: (src*a + dst*(255-a)) >> 8.
// Define ALPHA_BLENDER_ROUND_EN to round to nearest instead of truncating.
module alpha_channel_mix
  import alpha_blender_pkg::*;
(
  input  channel_t src,
  input  channel_t dst,
  input  channel_t alpha,
  output channel_t mixed
);

  logic [16:0] src_term;
  logic [16:0] dst_term;
  logic [16:0] sum;
  channel_t    inv_alpha;

  assign inv_alpha = ALPHA_MAX - alpha;
  assign src_term  = 17'(src) * 17'(alpha);
  assign dst_term  = 17'(dst) * 17'(inv_alpha);

`ifdef ALPHA_BLENDER_ROUND_EN
  assign sum = src_term + dst_term + 17'd128;
`else
  assign sum = src_term + dst_term;
`endif

  // Peak sum is 255*255 (+128), so bit 16 is never set.
  assign mixed = sum[15:8];

  logic unused_sum_bits;
  assign unused_sum_bits = ^{sum[16], sum[7:0]};

endmodule

// File: rtl/alpha_blender.sv
// Per-pixel alpha compositor: reads destination, writes blended pixel, forwards end-of-frame.
// Rounding mode is selected by ALPHA_BLENDER_ROUND_EN (see alpha_channel_mix).
module alpha_blender
  import alpha_blender_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] pixel_number,
  input  logic        pixel_ready,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic [7:0]  a,
  input  logic [7:0]  read_r,
  input  logic [7:0]  read_g,
  input  logic [7:0]  read_b,
  input  logic        frame_ready,
  output logic        o_frame_ready,
  output logic        read,
  output logic        write,
  output logic [7:0]  write_r,
  output logic [7:0]  write_g,
  output logic [7:0]  write_b
);

  localparam int unsigned LastStage = LATENCY - 1;

  // vld_q[0] is the capture stage, vld_q[LastStage] the write stage.
  logic [LastStage:0] vld_q;
  rgba_t              src_q;
  pixel_idx_t         idx_q   [0:LastStage];
  channel_t           res_r_q [1:LastStage];
  channel_t           res_g_q [1:LastStage];
  channel_t           res_b_q [1:LastStage];

  channel_t mix_r;
  channel_t mix_g;
  channel_t mix_b;

  logic pend_q;
  logic pend_d;
  logic frame_q;
  logic frame_fire;
  logic in_flight;

  alpha_channel_mix u_mix_r (
    .src   (src_q.r),
    .dst   (read_r),
    .alpha (src_q.a),
    .mixed (mix_r)
  );

  alpha_channel_mix u_mix_g (
    .src   (src_q.g),
    .dst   (read_g),
    .alpha (src_q.a),
    .mixed (mix_g)
  );

  alpha_channel_mix u_mix_b (
    .src   (src_q.b),
    .dst   (read_b),
    .alpha (src_q.a),
    .mixed (mix_b)
  );

  // A pixel sitting in the write stage has been issued, so it no longer holds the frame back.
  assign in_flight = |vld_q[LastStage-1:0];

  always_comb begin
    frame_fire = pend_q & ~in_flight;
    pend_d     = pend_q | frame_ready;
    if (frame_fire) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q   <= '0;
      src_q   <= '0;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
      for (int k = 0; k <= int'(LastStage); k++) begin
        idx_q[k] <= '0;
      end
      for (int k = 1; k <= int'(LastStage); k++) begin
        res_r_q[k] <= '0;
        res_g_q[k] <= '0;
        res_b_q[k] <= '0;
      end
    end else begin
      vld_q   <= {vld_q[LastStage-1:0], pixel_ready};
      pend_q  <= pend_d;
      frame_q <= frame_fire;

      if (pixel_ready) begin
        src_q.r  <= r;
        src_q.g  <= g;
        src_q.b  <= b;
        src_q.a  <= a;
        idx_q[0] <= pixel_number;
      end

      if (vld_q[0]) begin
        res_r_q[1] <= mix_r;
        res_g_q[1] <= mix_g;
        res_b_q[1] <= mix_b;
        idx_q[1]   <= idx_q[0];
      end

      // Stages load only on valid data so the write stage holds its last result.
      for (int k = 2; k <= int'(LastStage); k++) begin
        if (vld_q[k-1]) begin
          res_r_q[k] <= res_r_q[k-1];
          res_g_q[k] <= res_g_q[k-1];
          res_b_q[k] <= res_b_q[k-1];
          idx_q[k]   <= idx_q[k-1];
        end
      end
    end
  end

  assign read          = vld_q[0];
  assign write         = vld_q[LastStage];
  assign write_r       = res_r_q[LastStage];
  assign write_g       = res_g_q[LastStage];
  assign write_b       = res_b_q[LastStage];
  assign o_frame_ready = frame_q;

  // The pixel index rides along with its data but has no output on this port list.
  logic unused_idx;
  assign unused_idx = ^idx_q[LastStage];

endmodule

// File: tb/tb_alpha_blender.sv
// Directed bench for alpha_blender (default truncating build, LATENCY = 2).
module tb_alpha_blender;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] pixel_number;
  logic        pixel_ready;
  logic [7:0]  r, g, b, a;
  logic [7:0]  read_r, read_g, read_b;
  logic        frame_ready;
  logic        o_frame_ready;
  logic        read;
  logic        write;
  logic [7:0]  write_r, write_g, write_b;

  always #5 clk = ~clk;

  alpha_blender #(
    .LATENCY (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_number  (pixel_number),
    .pixel_ready   (pixel_ready),
    .r             (r),
    .g             (g),
    .b             (b),
    .a             (a),
    .read_r        (read_r),
    .read_g        (read_g),
    .read_b        (read_b),
    .frame_ready   (frame_ready),
    .o_frame_ready (o_frame_ready),
    .read          (read),
    .write         (write),
    .write_r       (write_r),
    .write_g       (write_g),
    .write_b       (write_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] s_r [4], s_g [4], s_b [4], s_a [4];
  logic [7:0] d_r [4], d_g [4], d_b [4];
  logic [7:0] e_r [4], e_g [4], e_b [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i,
                      input logic [7:0] sr, input logic [7:0] sg, input logic [7:0] sb,
                      input logic [7:0] sa,
                      input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    s_r[i] = sr; s_g[i] = sg; s_b[i] = sb; s_a[i] = sa;
    d_r[i] = dr; d_g[i] = dg; d_b[i] = db;
    e_r[i] = er; e_g[i] = eg; e_b[i] = eb;
  endtask

  // Pixel i is presented before edge i; its destination is driven in the following
  // cycle (while read is high) and its result is checked after edge i+1.
  task automatic run_burst(input int n, input bit frame_last, input string tag);
    for (int cyc = 0; cyc <= n + 2; cyc++) begin
      pixel_ready = (cyc < n);
      if (cyc < n) begin
        r = s_r[cyc]; g = s_g[cyc]; b = s_b[cyc]; a = s_a[cyc];
        pixel_number = 19'(cyc + 100);
      end
      frame_ready = frame_last && (cyc == n - 1);
      if (cyc >= 1 && cyc <= n) begin
        read_r = d_r[cyc-1]; read_g = d_g[cyc-1]; read_b = d_b[cyc-1];
      end else begin
        read_r = 8'hA5; read_g = 8'h5A; read_b = 8'hC3;
      end
      step();
      check_eq({tag, ".read"}, 32'(read), 32'(cyc < n));
      check_eq({tag, ".write"}, 32'(write), 32'(cyc >= 1 && cyc <= n));
      if (cyc >= 1 && cyc <= n) begin
        check_eq({tag, ".write_r"}, 32'(write_r), 32'(e_r[cyc-1]));
        check_eq({tag, ".write_g"}, 32'(write_g), 32'(e_g[cyc-1]));
        check_eq({tag, ".write_b"}, 32'(write_b), 32'(e_b[cyc-1]));
      end else if (cyc == n + 1) begin
        check_eq({tag, ".hold_r"}, 32'(write_r), 32'(e_r[n-1]));
        check_eq({tag, ".hold_b"}, 32'(write_b), 32'(e_b[n-1]));
      end
      check_eq({tag, ".o_frame_ready"}, 32'(o_frame_ready), 32'(frame_last && cyc == n + 1));
    end
    pixel_ready = 1'b0;
    frame_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pixel_ready = 1'b0; frame_ready = 1'b0; pixel_number = '0;
    r = '0; g = '0; b = '0; a = '0;
    read_r = '0; read_g = '0; read_b = '0;

    // Reset, with a pixel offered during the second reset cycle that must be ignored.
    step();
    pixel_ready = 1'b1; r = 8'd50; a = 8'd255; frame_ready = 1'b1;
    step();
    check_eq("rst.read", 32'(read), 32'd0);
    check_eq("rst.write", 32'(write), 32'd0);
    check_eq("rst.o_frame_ready", 32'(o_frame_ready), 32'd0);
    check_eq("rst.write_r", 32'(write_r), 32'd0);
    check_eq("rst.write_g", 32'(write_g), 32'd0);
    check_eq("rst.write_b", 32'(write_b), 32'd0);
    reset = 1'b1; pixel_ready = 1'b0; frame_ready = 1'b0;
    step();
    check_eq("rst_release.read", 32'(read), 32'd0);
    check_eq("rst_release.o_frame_ready", 32'(o_frame_ready), 32'd0);
    step();
    check_eq("rst_release.write", 32'(write), 32'd0);
    check_eq("rst_release.o_frame_ready2", 32'(o_frame_ready), 32'd0);

    // (128*17+1*238)>>8=9, (64*17+2*238)>>8=6, (192*17+3*238)>>8=15
    load(0, 128, 64, 192, 17, 1, 2, 3, 9, 6, 15);
    run_burst(1, 1'b0, "basic");

    // a=0: dst*255>>8
    load(0, 0, 0, 0, 0, 255, 170, 0, 254, 169, 0);
    run_burst(1, 1'b0, "transparent");

    // a=255: src*255>>8
    load(0, 0, 0, 0, 255, 255, 170, 0, 0, 0, 0);
    load(1, 255, 255, 255, 255, 255, 170, 0, 254, 254, 254);
    run_burst(2, 1'b0, "opaque");

    load(0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0);
    run_burst(1, 1'b0, "zero");

    // Four back-to-back pixels, frame_ready with the last one.
    load(0, 10, 20, 30, 128, 200, 100, 50, 104, 59, 39);
    load(1, 255, 0, 100, 64, 0, 255, 100, 63, 190, 99);
    load(2, 1, 2, 3, 255, 9, 9, 9, 0, 1, 2);
    load(3, 77, 88, 99, 200, 11, 22, 33, 62, 73, 84);
    run_burst(4, 1'b1, "stream");

    // End-of-frame with an empty pipe.
    frame_ready = 1'b1;
    step();
    check_eq("frame_empty.edge0", 32'(o_frame_ready), 32'd0);
    frame_ready = 1'b0;
    step();
    check_eq("frame_empty.edge1", 32'(o_frame_ready), 32'd1);
    step();
    check_eq("frame_empty.edge2", 32'(o_frame_ready), 32'd0);

    // A second frame_ready while pending merges into a single pulse.
    frame_ready = 1'b1;
    step();
    check_eq("frame_merge.edge0", 32'(o_frame_ready), 32'd0);
    step();
    check_eq("frame_merge.edge1", 32'(o_frame_ready), 32'd1);
    frame_ready = 1'b0;
    step();
    check_eq("frame_merge.edge2", 32'(o_frame_ready), 32'd0);
    step();
    check_eq("frame_merge.edge3", 32'(o_frame_ready), 32'd0);

    // Reset mid-flight drops the pixel and the pending frame.
    pixel_ready = 1'b1; frame_ready = 1'b1;
    r = 8'd200; g = 8'd200; b = 8'd200; a = 8'd255;
    step();
    check_eq("midrst.read", 32'(read), 32'd1);
    pixel_ready = 1'b0; frame_ready = 1'b0; reset = 1'b0;
    step();
    check_eq("midrst.write", 32'(write), 32'd0);
    check_eq("midrst.read_cleared", 32'(read), 32'd0);
    reset = 1'b1;
    step();
    check_eq("midrst.write_after", 32'(write), 32'd0);
    check_eq("midrst.write_r", 32'(write_r), 32'd0);
    check_eq("midrst.o_frame_ready", 32'(o_frame_ready), 32'd0);
    step();
    check_eq("midrst.o_frame_ready2", 32'(o_frame_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
